zap_dm_cache: RTL

Direct-mapped, read-allocate, write-through cache with an internal backing store and a refill state machine. It is the memory-side neighbour of `zap_top`. One instance feeds the instruction port (`o_data` drives the core's `i_instruction`, `o_hit` drives `i_valid`), and a second instance serves the data port (`o_miss` drives `i_data_stall`). It replaces the zero-latency memory model in core-level benches so that the core's stall, abort and recovery paths are exercised under realistic miss latency.

---
 rtl/zap_dm_cache.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/zap_dm_cache.sv
// Direct-mapped, read-allocate, write-through cache with internal backing store and refill FSM.
// Optional hit/miss performance counters are enabled by defining ZAP_DM_CACHE_PERF_EN.
module zap_dm_cache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_WORDS      = 1024,
    parameter int REFILL_LAT     = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic        i_recover,
    output logic [31:0] o_data,
    output logic        o_hit,
    output logic        o_miss,
    output logic        o_abort
`ifdef ZAP_DM_CACHE_PERF_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int LAT_W  = (REFILL_LAT > 1) ? $clog2(REFILL_LAT) : 1;
    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, next_state;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags      [LINES];
    logic [31:0]      line_data [LINES][WORDS_PER_LINE];
    logic [31:0]      backing   [MEM_WORDS];

    logic [IDX_W-1:0] refill_index;
    logic [TAG_W-1:0] refill_tag;
    logic [OFF_W-1:0] word_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             sticky_abort;

    logic [29:0]      word_idx;
    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             access;
    logic             out_of_range;
    logic             line_hit;
    logic             lat_wrap;
    logic             last_word;
    logic [MEM_AW-1:0] refill_addr;
    logic             start_refill;
    logic             do_write;
    logic             unused_byte_bits;

    assign word_idx         = i_address[31:2];
    assign offset           = word_idx[OFF_W-1:0];
    assign index            = word_idx[OFF_W +: IDX_W];
    assign tag              = word_idx[29 -: TAG_W];
    assign unused_byte_bits = ^i_address[1:0];

    assign access       = i_rd_en | i_wr_en;
    assign out_of_range = access && (word_idx >= MEM_LIMIT);
    assign line_hit     = valid[index] && (tags[index] == tag);
    assign lat_wrap     = (lat_cnt == LAT_W'(REFILL_LAT - 1));
    assign last_word    = (word_cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign refill_addr  = MEM_AW'({refill_tag, refill_index, word_cnt});

    // NOTE: every output and strobe gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state   = state;
        o_hit        = 1'b0;
        o_miss       = 1'b0;
        o_data       = '0;
        start_refill = 1'b0;
        do_write     = 1'b0;
        o_abort      = sticky_abort | out_of_range;
        case (state)
            IDLE: begin
                if (access && !out_of_range) begin
                    if (i_wr_en) begin
                        o_hit    = 1'b1;
                        do_write = 1'b1;
                    end else if (line_hit) begin
                        o_hit  = 1'b1;
                        o_data = line_data[index][offset];
                    end else begin
                        o_miss       = 1'b1;
                        start_refill = 1'b1;
                        next_state   = REFILL;
                    end
                end
            end
            REFILL: begin
                o_miss = access && !out_of_range;
                if (lat_wrap && last_word) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            valid        <= '0;
            word_cnt     <= '0;
            lat_cnt      <= '0;
            sticky_abort <= 1'b0;
            refill_index <= '0;
            refill_tag   <= '0;
        end else begin
            state <= next_state;

            if (i_recover)         sticky_abort <= 1'b0;
            else if (out_of_range) sticky_abort <= 1'b1;

            if (start_refill) begin
                // The victim line is invalidated up front so a partial fill can never be hit.
                refill_index <= index;
                refill_tag   <= tag;
                valid[index] <= 1'b0;
                word_cnt     <= '0;
                lat_cnt      <= '0;
            end else if (state == REFILL) begin
                if (lat_wrap) begin
                    lat_cnt  <= '0;
                    word_cnt <= word_cnt + 1'b1;
                    if (last_word) valid[refill_index] <= 1'b1;
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: data, tag and backing arrays are not reset; the valid bits alone decide what is usable.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            backing[word_idx[MEM_AW-1:0]] <= i_data;
            if (line_hit) line_data[index][offset] <= i_data;
        end
        if (state == REFILL && lat_wrap) begin
            line_data[refill_index][word_cnt] <= backing[refill_addr];
            if (last_word) tags[refill_index] <= refill_tag;
        end
    end

`ifdef ZAP_DM_CACHE_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            o_hit_count  <= o_hit_count + 32'(o_hit);
            o_miss_count <= o_miss_count + 32'(start_refill);
        end
    end
`endif

endmodule
